party_computation_sched: RTL and testbench
==========================================

# party_computation_sched

Iteration scheduler for the MPC party-computation engine in the signing datapath. It steps through the TAU repetitions and, for each one, fetches the per-repetition challenge words (r, eps) from the challenge memory. It then starts the engine, waits for its done pulse, and stores the engine's alpha, beta and v outputs into the response memory. It sits between the sign top-level controller and the party computation engine; the shared a/b/minus_c/alpha_prime/beta_prime inputs are routed to the engine directly and do not pass through this block.

## Interface
- TAU, 17, number of repetitions (iterations)
- T, 3, number of 32-bit field-extension words per challenge/result bus
- i_clk  in  1  clock; all logic on its rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  begin a full TAU-iteration run; sampled only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the run is complete
- o_iter  out  CLOG2(TAU)  current iteration index e
- o_chal_addr  out  CLOG2(2*TAU)  challenge memory address (r at 2e, eps at 2e+1)
- o_chal_rd  out  1  challenge memory read strobe
- i_chal  in  T*32  challenge memory read data, valid one cycle after the address
- o_pc_start  out  1  one-cycle start pulse to the engine
- o_pc_r  out  T*32  registered r for the current iteration
- o_pc_eps  out  T*32  registered eps for the current iteration
- i_pc_done  in  1  engine completion pulse
- i_pc_alpha, i_pc_beta, i_pc_v  in  T*32 each  engine results, valid in the cycle i_pc_done is high
- o_res_addr  out  CLOG2(3*TAU)  response memory address (alpha 3e, beta 3e+1, v 3e+2)
- o_res_wr  out  1  response memory write enable
- o_res_data  out  T*32  response write data

## Operation
States and transitions:
- IDLE: if i_start, clear e to 0 and go to RD_R.
- RD_R: o_chal_rd=1, o_chal_addr=2e. Go to RD_EPS.
- RD_EPS: o_chal_rd=1, o_chal_addr=2e+1. Latch i_chal into o_pc_r. Go to LATCH.
- LATCH: latch i_chal into o_pc_eps. Go to START.
- START: o_pc_start=1. Go to WAIT.
- WAIT: stay until i_pc_done=1. In that cycle, capture alpha, beta and v into internal registers, then go to WR_A.
- WR_A / WR_B / WR_V: o_res_wr=1 in each, with addr = 3e / 3e+1 / 3e+2 and data = alpha / beta / v respectively.
- After WR_V: if e==TAU-1, go to DONE; otherwise increment e and go to RD_R.
- DONE: o_done=1, then go to IDLE.

Rules:
- i_start outside IDLE is ignored.
- i_pc_done outside WAIT is ignored; this includes a pulse in the START cycle.
- o_pc_r and o_pc_eps hold their value from LATCH until they are overwritten in the next iteration, so the engine may sample them at any time during its run.
- Address arithmetic is unsigned and sized to the port widths. e never exceeds TAU-1, so no wrap occurs.

## Timing
- Reset: registered during i_rst; outputs take reset values on the first clock edge with i_rst high.
  - State goes to IDLE and e to 0.
  - Every output is 0: o_busy, o_done, o_iter, o_chal_*, o_pc_*, o_res_*.
- Reset mid-run aborts immediately. No further writes or start pulses are issued. A new i_start is accepted on the first cycle after i_rst deasserts.
- Control outputs (o_chal_rd, o_pc_start, o_res_wr, o_done) are decoded from the current state; the data/address registers are clocked.
- Let L be the number of cycles from o_pc_start high to i_pc_done high (L >= 1).
  - Each iteration takes 7+L cycles.
  - With i_start high in cycle 0, RD_R occurs in cycle 1.
  - o_done is high in cycle 1 + TAU*(7+L).
- Back-to-back runs: i_start asserted in the cycle after DONE (state IDLE) is accepted.

## Test plan
- Basic run: TAU=17, T=3, engine model with fixed L=5, challenge memory word k = {3{k}} -> exactly 17 o_pc_start pulses; o_done at cycle 205; response address 3e holds the model's alpha for r={3{2e}}, eps={3{2e+1}}; 51 writes total; no write to addresses 51-63.
- Variable latency: per-iteration L from 1 to 40 (random) -> per-iteration spacing is 7+L; o_pc_r and o_pc_eps are stable across each WAIT.
- Spurious inputs: i_pc_done pulsed in START and in RD_R, and i_start re-pulsed while busy -> ignored; results and o_done cycle are identical to the basic run.
- Reset mid-run: assert i_rst during WAIT of e=8 -> next cycle all outputs are 0 and state is IDLE; no o_res_wr afterwards; a new i_start gives a full clean run starting at e=0.
- Boundary: TAU=1 -> a single iteration, addresses 0-1 read and 0-2 written, o_done at cycle 8+L; back-to-back i_start right after o_done starts a second run.

Source files
------------

// File: rtl/party_computation_sched.sv
// Iteration scheduler for the MPC party-computation engine: per repetition it fetches (r, eps),
// runs the engine once and writes alpha/beta/v back to the response memory.
module party_computation_sched #(
  parameter int unsigned TAU = 17,
  parameter int unsigned T   = 3,
  localparam int unsigned IW = (TAU > 1) ? $clog2(TAU) : 1,
  localparam int unsigned CW = $clog2(2 * TAU),
  localparam int unsigned RW = $clog2(3 * TAU),
  localparam int unsigned DW = T * 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [IW-1:0] o_iter,
  output logic [CW-1:0] o_chal_addr,
  output logic          o_chal_rd,
  input  logic [DW-1:0] i_chal,
  output logic          o_pc_start,
  output logic [DW-1:0] o_pc_r,
  output logic [DW-1:0] o_pc_eps,
  input  logic          i_pc_done,
  input  logic [DW-1:0] i_pc_alpha,
  input  logic [DW-1:0] i_pc_beta,
  input  logic [DW-1:0] i_pc_v,
  output logic [RW-1:0] o_res_addr,
  output logic          o_res_wr,
  output logic [DW-1:0] o_res_data
);

  typedef enum logic [3:0] {
    StIdle, StRdR, StRdEps, StLatch, StStart, StWait, StWrA, StWrB, StWrV, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] e_q, e_d;
  logic [CW-1:0] chal_addr_q, chal_addr_d;
  logic [DW-1:0] pc_r_q, pc_r_d, pc_eps_q, pc_eps_d;
  logic [DW-1:0] beta_q, beta_d, v_q, v_d;
  logic [RW-1:0] res_addr_q, res_addr_d;
  logic [DW-1:0] res_data_q, res_data_d;

  logic [IW-1:0] e_next;
  logic [CW-1:0] e_c, e_next_c;
  logic [RW-1:0] e_r, e3;

  assign e_next   = e_q + IW'(1);
  assign e_c      = CW'(e_q);
  assign e_next_c = CW'(e_next);
  assign e_r      = RW'(e_q);
  assign e3       = e_r + e_r + e_r;

  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    chal_addr_d = chal_addr_q;
    pc_r_d      = pc_r_q;
    pc_eps_d    = pc_eps_q;
    beta_d      = beta_q;
    v_d         = v_q;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          e_d         = '0;
          chal_addr_d = '0;
          state_d     = StRdR;
        end
      end
      StRdR: begin
        chal_addr_d = (e_c << 1) + CW'(1);
        state_d     = StRdEps;
      end
      StRdEps: begin
        pc_r_d  = i_chal;
        state_d = StLatch;
      end
      StLatch: begin
        pc_eps_d = i_chal;
        state_d  = StStart;
      end
      StStart: state_d = StWait;
      StWait: begin
        if (i_pc_done) begin
          // alpha goes straight into the write-data register; beta and v wait their turn
          res_addr_d = e3;
          res_data_d = i_pc_alpha;
          beta_d     = i_pc_beta;
          v_d        = i_pc_v;
          state_d    = StWrA;
        end
      end
      StWrA: begin
        res_addr_d = e3 + RW'(1);
        res_data_d = beta_q;
        state_d    = StWrB;
      end
      StWrB: begin
        res_addr_d = e3 + RW'(2);
        res_data_d = v_q;
        state_d    = StWrV;
      end
      StWrV: begin
        if (e_q == IW'(TAU - 1)) begin
          state_d = StDone;
        end else begin
          e_d         = e_next;
          chal_addr_d = e_next_c << 1;
          state_d     = StRdR;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      e_q         <= '0;
      chal_addr_q <= '0;
      pc_r_q      <= '0;
      pc_eps_q    <= '0;
      beta_q      <= '0;
      v_q         <= '0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      e_q         <= e_d;
      chal_addr_q <= chal_addr_d;
      pc_r_q      <= pc_r_d;
      pc_eps_q    <= pc_eps_d;
      beta_q      <= beta_d;
      v_q         <= v_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
    end
  end

  assign o_busy      = (state_q != StIdle);
  assign o_done      = (state_q == StDone);
  assign o_chal_rd   = (state_q == StRdR) || (state_q == StRdEps);
  assign o_pc_start  = (state_q == StStart);
  assign o_res_wr    = (state_q == StWrA) || (state_q == StWrB) || (state_q == StWrV);
  assign o_iter      = e_q;
  assign o_chal_addr = chal_addr_q;
  assign o_pc_r      = pc_r_q;
  assign o_pc_eps    = pc_eps_q;
  assign o_res_addr  = res_addr_q;
  assign o_res_data  = res_data_q;

endmodule

// File: tb/tb_party_computation_sched.sv
// Scoreboard bench: TAU=17 and TAU=1 schedulers share one challenge-memory / engine model.
module tb_party_computation_sched;

  typedef struct {
    logic [5:0]  addr;
    logic [95:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst = 1'b1, start = 1'b0, sel = 1'b0, spur = 1'b0;
  logic        pc_done = 1'b0;
  logic [95:0] chal = '0, pc_alpha = '0, pc_beta = '0, pc_v = '0;
  logic        start0, start1;
  assign start0 = start && !sel;
  assign start1 = start && sel;

  logic busy0, done0, crd0, pcs0, rwr0;
  logic [4:0] iter0;
  logic [5:0] caddr0, raddr0;
  logic [95:0] pr0, pe0, rdata0;
  logic busy1, done1, crd1, pcs1, rwr1;
  logic [0:0] iter1, caddr1;
  logic [1:0] raddr1;
  logic [95:0] pr1, pe1, rdata1;

  party_computation_sched #(.TAU(17), .T(3)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_busy(busy0), .o_done(done0),
    .o_iter(iter0), .o_chal_addr(caddr0), .o_chal_rd(crd0), .i_chal(chal),
    .o_pc_start(pcs0), .o_pc_r(pr0), .o_pc_eps(pe0), .i_pc_done(pc_done),
    .i_pc_alpha(pc_alpha), .i_pc_beta(pc_beta), .i_pc_v(pc_v),
    .o_res_addr(raddr0), .o_res_wr(rwr0), .o_res_data(rdata0)
  );

  party_computation_sched #(.TAU(1), .T(3)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_iter(iter1), .o_chal_addr(caddr1), .o_chal_rd(crd1), .i_chal(chal),
    .o_pc_start(pcs1), .o_pc_r(pr1), .o_pc_eps(pe1), .i_pc_done(pc_done),
    .i_pc_alpha(pc_alpha), .i_pc_beta(pc_beta), .i_pc_v(pc_v),
    .o_res_addr(raddr1), .o_res_wr(rwr1), .o_res_data(rdata1)
  );

  logic        m_busy, m_done, m_crd, m_pcs, m_rwr;
  logic [4:0]  m_iter;
  logic [5:0]  m_caddr, m_raddr;
  logic [95:0] m_pr, m_pe, m_rdata;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;
  assign m_crd   = sel ? crd1 : crd0;
  assign m_pcs   = sel ? pcs1 : pcs0;
  assign m_rwr   = sel ? rwr1 : rwr0;
  assign m_iter  = sel ? 5'(iter1) : iter0;
  assign m_caddr = sel ? 6'(caddr1) : caddr0;
  assign m_raddr = sel ? 6'(raddr1) : raddr0;
  assign m_pr    = sel ? pr1 : pr0;
  assign m_pe    = sel ? pe1 : pe0;
  assign m_rdata = sel ? rdata1 : rdata0;

  int n_tests = 0, n_fail = 0, n_pcs = 0, n_done = 0;
  int lat[17];
  wr_t exp_q[$];
  int  done_q[$];

  function automatic logic [95:0] w(input int k);
    return {3{32'(k)}};
  endfunction
  function automatic logic [95:0] fa(input logic [95:0] r, input logic [95:0] e);
    return r ^ {e[47:0], e[95:48]};
  endfunction
  function automatic logic [95:0] fb(input logic [95:0] r, input logic [95:0] e);
    return r + e;
  endfunction
  function automatic logic [95:0] fv(input logic [95:0] r, input logic [95:0] e);
    return ~r ^ {e[31:0], e[95:32]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected writes and done cycle for a run whose i_start is high in cycle st.
  task automatic push_run(input int tau, input int st);
    int t;
    wr_t x;
    t = st + 1;
    for (int e = 0; e < tau; e++) begin
      x.addr = 6'(3 * e);     x.data = fa(w(2 * e), w(2 * e + 1)); exp_q.push_back(x);
      x.addr = 6'(3 * e + 1); x.data = fb(w(2 * e), w(2 * e + 1)); exp_q.push_back(x);
      x.addr = 6'(3 * e + 2); x.data = fv(w(2 * e), w(2 * e + 1)); exp_q.push_back(x);
      t += 7 + lat[e];
    end
    done_q.push_back(t);
  endtask

  task automatic run(input int tau, input bit repulse);
    int p0, d0;
    p0 = n_pcs;
    d0 = n_done;
    push_run(tau, cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (repulse) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 4000 && n_done == d0; i++) tick();
    if (n_done == d0) fail_now("done_timeout");
    chk("start_pulses", 128'(n_pcs - p0), 128'(tau));
    chk("writes_left", 128'(exp_q.size()), 128'(0));
  endtask

  // Challenge memory (1-cycle read latency) and engine model with per-iteration latency.
  initial begin
    int cnt = 0;
    logic [5:0] pend = '0;
    logic pend_v = 1'b0;
    logic [95:0] r0 = '0, e0 = '0;
    forever begin
      tick();
      pc_done = 1'b0;
      chal = pend_v ? w(int'(pend)) : '0;
      pend_v = m_crd;
      pend = m_caddr;
      if (!m_busy) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          chk("pc_r_stable", m_pr, r0);
          chk("pc_eps_stable", m_pe, e0);
          pc_done = 1'b1;
          pc_alpha = fa(m_pr, m_pe);
          pc_beta = fb(m_pr, m_pe);
          pc_v = fv(m_pr, m_pe);
        end
      end
      if (m_pcs) begin
        cnt = lat[int'(m_iter)];
        r0 = m_pr;
        e0 = m_pe;
      end
      if (spur && (m_pcs || (m_crd && !m_caddr[0]))) begin
        pc_done = 1'b1;
        pc_alpha = '1;
        pc_beta = '1;
        pc_v = '1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  initial begin
    wr_t x;
    forever begin
      @(negedge clk);
      if (m_pcs) n_pcs++;
      if (m_rwr) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          x = exp_q.pop_front();
          chk("res_addr", 128'(m_raddr), 128'(x.addr));
          chk("res_data", 128'(m_rdata), 128'(x.data));
        end
      end
      if (m_done) begin
        n_done++;
        if (done_q.size() == 0) fail_now("unexpected_done");
        else chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_zero();
    chk("rst_ctrl", 128'({busy0, done0, iter0, caddr0, crd0, pcs0, raddr0, rwr0}), 128'(0));
    chk("rst_pc_r", 128'(pr0), 128'(0));
    chk("rst_pc_eps", 128'(pe0), 128'(0));
    chk("rst_res_data", 128'(rdata0), 128'(0));
  endtask

  initial begin
    int lat_var[17] = '{1, 40, 3, 7, 12, 2, 25, 5, 9, 33, 1, 18, 4, 27, 6, 11, 2};
    bit hit;
    rst = 1'b1;
    repeat (2) tick();
    chk_reset_zero();
    chk("rst_dut1", 128'({busy1, done1, iter1, caddr1, crd1, pcs1, raddr1, rwr1, pr1, rdata1}),
        128'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) lat[i] = 5;
    run(17, 1'b0);
    repeat (3) tick();

    lat = lat_var;
    run(17, 1'b0);
    repeat (3) tick();

    for (int i = 0; i < 17; i++) lat[i] = 5;
    spur = 1'b1;
    run(17, 1'b1);
    spur = 1'b0;
    repeat (3) tick();

    // Abort during WAIT of e=8, then restart on the first cycle after reset drops.
    push_run(17, cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (m_pcs && m_iter == 5'd8) hit = 1'b1;
      else tick();
    end
    if (!hit) fail_now("reach_e8");
    repeat (2) tick();
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    tick();
    chk_reset_zero();
    rst = 1'b0;
    run(17, 1'b0);
    repeat (3) tick();

    sel = 1'b1;
    lat[0] = 5;
    run(1, 1'b0);
    run(1, 1'b0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
